// File: rtl/complex_mult_pkg.sv
// Shared constants for the complex multiplier scheduler.
// A complex operand is 64 bits: real half in [63:32], imaginary half in
// [31:0], each an IEEE-754 single-precision value. The scheduler never
// interprets these fields. It only routes them to and from the multiplier.
package complex_mult_pkg;

    localparam int CPLX_W      = 64;
    localparam int HALF_W      = 32;
    localparam int DEF_LATENCY = 8;
    localparam int DEF_NREQ    = 4;

    // Field slice positions inside a packed complex word
    localparam int REAL_MSB = 63;
    localparam int REAL_LSB = 32;
    localparam int IMAG_MSB = 31;
    localparam int IMAG_LSB = 0;

    // Requester id width; at least one bit so a 1-wide id is still legal
    function automatic int id_width(input int nreq);
        return (nreq <= 1) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/complex_mult_scheduler_rr_arbiter.sv
// Round-robin arbiter used by complex_mult_scheduler.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   req[NREQ]     request vector
//   en            arbitration enable (the multiplier clock enable)
//   gnt[NREQ]     one-hot grant, zero when en=0 or no request
//   gnt_idx[IDW]  encoded index of the winner
//   gnt_any       a grant was issued this cycle
// The pointer holds the last winner. The scan starts one above it, so
// after reset (pointer = NREQ-1) requester 0 has top priority.
module rr_arbiter
    import complex_mult_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = id_width(DEF_NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_any
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW:0]   sum_v;
    logic [IDW-1:0] idx_v;
    logic           hit_v;

    // Priority scan from ptr+1 upward with wrap; the first hit wins.
    // ptr+off never exceeds 2*NREQ-1, so one conditional subtract suffices.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sum_v   = '0;
        idx_v   = '0;
        hit_v   = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            sum_v   = {1'b0, ptr_q} + (IDW+1)'(off);
            idx_v   = (sum_v >= (IDW+1)'(NREQ)) ? IDW'(sum_v - (IDW+1)'(NREQ)) : IDW'(sum_v);
            hit_v   = en & ~gnt_any & req[idx_v];
            gnt[idx_v] = gnt[idx_v] | hit_v;
            gnt_idx = hit_v ? idx_v : gnt_idx;
            gnt_any = gnt_any | hit_v;
        end
    end

    // Pointer follows the winner only when a grant actually happens
    always_comb begin
        ptr_d = (en & gnt_any) ? gnt_idx : ptr_q;
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IDW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/complex_mult_scheduler.sv
// Shares one pipelined complex multiplier among NREQ requesters.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   req_valid    per-requester operand valid
//   req_ready    one-hot grant (transfer when valid & ready)
//   req_a/req_b  packed operands, requester i at [64*i +: 64]
//   mul_a/mul_b  operands of the granted requester; zero when there is no grant
//   mul_ce       clock enable for the multiplier and the internal tag pipe
//   mul_result   product from the multiplier
//   out_valid    product valid, out_id is its owner, out_result = mul_result
//   out_ready    downstream accept
//   inflight     products issued but not yet accepted
// A tag pipe of LATENCY {valid,id} stages runs in lockstep with the
// multiplier. When the output is stalled, mul_ce drops. The multiplier and
// the tags then freeze together, and the tags stay aligned with the products.
module complex_mult_scheduler
    import complex_mult_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int LATENCY = DEF_LATENCY,
    parameter int IDW     = id_width(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*CPLX_W-1:0]     req_a,
    input  logic [NREQ*CPLX_W-1:0]     req_b,
    output logic [CPLX_W-1:0]          mul_a,
    output logic [CPLX_W-1:0]          mul_b,
    output logic                       mul_ce,
    input  logic [CPLX_W-1:0]          mul_result,
    output logic                       out_valid,
    output logic [IDW-1:0]             out_id,
    output logic [CPLX_W-1:0]          out_result,
    input  logic                       out_ready,
    output logic [$clog2(LATENCY+1)-1:0] inflight
);

    localparam int CNTW = $clog2(LATENCY + 1);

    logic [NREQ-1:0]              gnt;
    logic [IDW-1:0]               gnt_idx;
    logic                         gnt_any;
    logic                         stall;
    logic                         issue;
    logic                         accept;

    logic [LATENCY-1:0]           tag_valid_q;
    logic [LATENCY-1:0]           tag_valid_d;
    logic [LATENCY-1:0][IDW-1:0]  tag_id_q;
    logic [LATENCY-1:0][IDW-1:0]  tag_id_d;
    logic [CNTW-1:0]              inflight_q;
    logic [CNTW-1:0]              inflight_d;

    // Stall and enable. Reset masks out_valid at once, so no stale product
    // shows while rst is high.
    always_comb begin
        out_valid = tag_valid_q[LATENCY-1] & ~rst;
        stall     = out_valid & ~out_ready;
        mul_ce    = ~stall & ~rst;
        issue     = mul_ce & gnt_any;
        accept    = out_valid & out_ready;
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .en      (mul_ce),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // One-hot operand mux: AND-OR select gives zero when there is no grant
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            mul_a = mul_a | ({CPLX_W{gnt[i]}} & req_a[CPLX_W*i +: CPLX_W]);
            mul_b = mul_b | ({CPLX_W{gnt[i]}} & req_b[CPLX_W*i +: CPLX_W]);
        end
    end

    // Tag pipe next state: shift on ce, otherwise hold
    always_comb begin
        tag_valid_d = tag_valid_q;
        tag_id_d    = tag_id_q;
        if (mul_ce) begin
            tag_valid_d[0] = gnt_any;
            tag_id_d[0]    = gnt_idx;
            for (int s = 1; s < LATENCY; s++) begin
                tag_valid_d[s] = tag_valid_q[s-1];
                tag_id_d[s]    = tag_id_q[s-1];
            end
        end else begin
            tag_valid_d = tag_valid_q;
            tag_id_d    = tag_id_q;
        end
    end

    // Outstanding-product counter: a simultaneous issue and accept cancel out
    always_comb begin
        case ({issue, accept})
            2'b10:   inflight_d = inflight_q + CNTW'(1);
            2'b01:   inflight_d = inflight_q - CNTW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers. Reset clears the valid bits, so in-flight products vanish.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_q <= '0;
            tag_id_q    <= '0;
            inflight_q  <= '0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
            inflight_q  <= inflight_d;
        end
    end

    // Output assignments
    always_comb begin
        req_ready  = gnt;
        out_id     = tag_id_q[LATENCY-1];
        out_result = mul_result;
        inflight   = inflight_q;
    end

endmodule

// File: tb/tb_complex_mult_scheduler.sv
module tb_complex_mult_scheduler;

    localparam int LAT = 8;
    localparam logic [63:0] A1 = 64'h3F800000_40000000;
    localparam logic [63:0] B1 = 64'h40400000_40800000;
    localparam logic [63:0] C1 = 64'hC0A00000_41200000;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [255:0] req_a;
    logic [255:0] req_b;
    logic [63:0]  mul_a;
    logic [63:0]  mul_b;
    logic         mul_ce;
    logic [63:0]  mul_result;
    logic         out_valid;
    logic [1:0]   out_id;
    logic [63:0]  out_result;
    logic         out_ready;
    logic [3:0]   inflight;

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;
    int step   = 0;
    bit use_fp = 1'b0;

    logic [1:0]  exp_id_q  [$];
    logic [63:0] exp_res_q [$];
    logic [63:0] dp [LAT];

    always #5 clk = ~clk;

    complex_mult_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_ce     (mul_ce),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_id     (out_id),
        .out_result (out_result),
        .out_ready  (out_ready),
        .inflight   (inflight)
    );

    // Stand-in multiplier: the known complex product for the float vector,
    // otherwise an arbitrary bijective mix so each operand pair is traceable
    function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
        if (a == A1 && b == B1) return C1;
        return a ^ {b[31:0], b[63:32]};
    endfunction

    // ce-gated datapath model with LAT stages
    always @(posedge clk) begin
        if (mul_ce) begin
            dp[0] <= fmul(mul_a, mul_b);
            for (int s = 1; s < LAT; s++) dp[s] <= dp[s-1];
        end
    end
    assign mul_result = dp[LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check shortly after.
    // eg = expected grant (-1 none), eov/einf = expected out_valid/inflight (-1 skip)
    task automatic cycle(input logic [3:0] v, input logic ordy, input logic r,
                         input int eg, input int eov, input int einf);
        logic [63:0] a_i, b_i;
        @(negedge clk);
        rst       = r;
        req_valid = v;
        out_ready = ordy;
        for (int i = 0; i < 4; i++) begin
            a_i = {4'h1, 4'(i), 24'(step), 32'h3F800000 ^ 32'(step)};
            b_i = {4'h2, 4'(i), 24'(step), 32'(step * 3 + i)};
            if (use_fp && i == 0) begin
                a_i = A1;
                b_i = B1;
            end
            req_a[64*i +: 64] = a_i;
            req_b[64*i +: 64] = b_i;
        end
        step++;
        #1;
        if (eg < 0) begin
            chk("req_ready", 64'(req_ready), 64'd0);
            chk("mul_a_zero", mul_a, 64'd0);
        end else begin
            chk("req_ready", 64'(req_ready), 64'(4'b0001 << eg));
            chk("mul_a", mul_a, req_a[64*eg +: 64]);
            chk("mul_b", mul_b, req_b[64*eg +: 64]);
            exp_id_q.push_back(2'(eg));
            exp_res_q.push_back(fmul(req_a[64*eg +: 64], req_b[64*eg +: 64]));
        end
        if (out_valid === 1'b1) begin
            chk("out_expected", 64'(exp_id_q.size() != 0), 64'd1);
            if (exp_id_q.size() != 0) begin
                chk("out_id", 64'(out_id), 64'(exp_id_q[0]));
                chk("out_result", out_result, exp_res_q[0]);
                if (ordy) begin
                    void'(exp_id_q.pop_front());
                    void'(exp_res_q.pop_front());
                end
            end
        end
        if (eov >= 0) chk("out_valid", 64'(out_valid), 64'(eov));
        if (einf >= 0) chk("inflight", 64'(inflight), 64'(einf));
    endtask

    initial begin
        rst = 1'b1; req_valid = 4'd0; out_ready = 1'b1; req_a = '0; req_b = '0;
        for (int s = 0; s < LAT; s++) dp[s] = 64'd0;

        // Reset state
        cycle(4'b1111, 1'b1, 1'b1, -1, 0, -1);
        chk("rst_ce", 64'(mul_ce), 64'd0);
        cycle(4'b0000, 1'b1, 1'b0, -1, 0, 0);
        chk("idle_ce", 64'(mul_ce), 64'd1);

        // All four requesting, out_ready high: 0,1,2,3,... one per cycle
        for (int k = 0; k < 12; k++)
            cycle(4'b1111, 1'b1, 1'b0, k % 4, (k >= LAT) ? 1 : 0, (k < LAT) ? k : LAT);

        // Backpressure for 3 cycles: frozen, no grants
        for (int k = 0; k < 3; k++) begin
            cycle(4'b1111, 1'b0, 1'b0, -1, 1, LAT);
            chk("stall_ce", 64'(mul_ce), 64'd0);
        end
        // Release: arbitration resumes where it stopped
        for (int k = 0; k < 4; k++)
            cycle(4'b1111, 1'b1, 1'b0, k % 4, 1, LAT);
        // Drain
        for (int k = 0; k < LAT + 2; k++)
            cycle(4'b0000, 1'b1, 1'b0, -1, (k < LAT) ? 1 : 0, LAT - ((k < LAT) ? k : LAT));
        chk("drain_empty", 64'(exp_id_q.size()), 64'd0);

        // Single float product from req0, LAT-cycle latency
        use_fp = 1'b1;
        cycle(4'b0001, 1'b1, 1'b0, 0, 0, 0);
        use_fp = 1'b0;
        for (int k = 1; k < LAT; k++) cycle(4'b0000, 1'b1, 1'b0, -1, 0, 1);
        cycle(4'b0000, 1'b1, 1'b0, -1, 1, 1);
        chk("fp_id", 64'(out_id), 64'd0);
        chk("fp_result", out_result, C1);
        cycle(4'b0000, 1'b1, 1'b0, -1, 0, 0);

        // Reset with 5 products in flight
        for (int k = 0; k < 5; k++) cycle(4'b0001, 1'b1, 1'b0, 0, 0, k);
        cycle(4'b0001, 1'b1, 1'b1, -1, 0, 5);
        chk("rst_mid_ce", 64'(mul_ce), 64'd0);
        exp_id_q.delete();
        exp_res_q.delete();
        for (int k = 0; k < LAT + 1; k++) cycle(4'b0000, 1'b1, 1'b0, -1, 0, 0);

        // Pointer at 2, then req1 and req3 together: 3 before 1
        cycle(4'b0100, 1'b1, 1'b0, 2, 0, 0);
        cycle(4'b1010, 1'b1, 1'b0, 3, 0, 1);
        cycle(4'b1010, 1'b1, 1'b0, 1, 0, 2);
        for (int k = 0; k < LAT + 1; k++) cycle(4'b0000, 1'b1, 1'b0, -1, -1, -1);
        chk("rr_empty", 64'(exp_id_q.size()), 64'd0);

        // Req0 every other cycle: output toggles, inflight bounded by LAT/2
        for (int k = 0; k < 20; k++) begin
            cycle((k % 2 == 0) ? 4'b0001 : 4'b0000, 1'b1, 1'b0,
                  (k % 2 == 0) ? 0 : -1, (k >= LAT && k % 2 == 0) ? 1 : 0, -1);
            chk("inflight_max", 64'(inflight <= 4'd4), 64'd1);
        end
        for (int k = 0; k < LAT + 1; k++) cycle(4'b0000, 1'b1, 1'b0, -1, -1, -1);
        chk("alt_empty", 64'(exp_id_q.size()), 64'd0);
        chk("final_inflight", 64'(inflight), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
